// File: rtl/boot_loaded_memory.sv
// Unified 16-bit instruction/data memory with a post-reset clear sweep, a streaming
// boot-loader phase and byte/word access with alignment checking. All state moves on negedge clk.
module boot_loaded_memory #(
  parameter int ADDR_W       = 7,
  parameter bit CLEAR_ON_RST = 1'b1,
  parameter bit LOAD_EN      = 1'b1
) (
  input  logic              clk,
  input  logic              proc_rst,
  input  logic              ld_valid,
  input  logic [15:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       in,
  input  logic              word_mode,
  input  logic              write,
  input  logic              read,
  output logic [15:0]       out,
  output logic              out_valid,
  output logic              err_align
);

  localparam int                DATA_W   = 16;
  localparam int                IDX_W    = ADDR_W - 1;
  localparam int                DEPTH    = 1 << IDX_W;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {ST_INIT, ST_LOAD, ST_RUN} state_t;

  state_t            state;
  logic [IDX_W-1:0]  clr_ptr;
  logic [IDX_W-1:0]  ld_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ld_ready_q;
  logic              mem_ready_q;
  logic [DATA_W-1:0] out_p1;
  logic              vld_p1;
  logic              err_p1;

  function automatic logic signed [DATA_W-1:0] sext_byte(input logic [7:0] b);
    return {{(DATA_W-8){b[7]}}, b};
  endfunction

  // Stage p0: decode strobes and pick the single array write port user
  logic [IDX_W-1:0]  idx_p0;
  logic              rd_req_p0;
  logic              wr_req_p0;
  logic              misalign_p0;
  logic              do_rd_p0;
  logic              do_wr_p0;
  logic              ld_xfer_p0;
  logic              clr_wr_p0;
  logic [DATA_W-1:0] rd_word_p0;
  logic [DATA_W-1:0] rd_val_p0;
  logic              we_lo_p0;
  logic              we_hi_p0;
  logic [IDX_W-1:0]  widx_p0;
  logic [DATA_W-1:0] wdata_p0;

  always_comb begin
    idx_p0      = addr[ADDR_W-1:1];
    rd_req_p0   = (state == ST_RUN) && !read;
    wr_req_p0   = (state == ST_RUN) && !write;
    misalign_p0 = word_mode && addr[0] && (rd_req_p0 || wr_req_p0);
    do_rd_p0    = rd_req_p0 && !misalign_p0;
    do_wr_p0    = wr_req_p0 && !misalign_p0;
    ld_xfer_p0  = (state == ST_LOAD) && ld_valid && ld_ready_q;
    clr_wr_p0   = (state == ST_INIT) && CLEAR_ON_RST;
    rd_word_p0  = mem[idx_p0];
    if (word_mode)
      rd_val_p0 = rd_word_p0;
    else if (addr[0])
      rd_val_p0 = unsigned'(sext_byte(rd_word_p0[15:8]));
    else
      rd_val_p0 = unsigned'(sext_byte(rd_word_p0[7:0]));
  end

  // Reset must also block array writes so an abort never commits a stray word
  always_comb begin
    we_lo_p0 = 1'b0;
    we_hi_p0 = 1'b0;
    widx_p0  = '0;
    wdata_p0 = '0;
    if (proc_rst) begin
      if (clr_wr_p0) begin
        we_lo_p0 = 1'b1;
        we_hi_p0 = 1'b1;
        widx_p0  = clr_ptr;
      end else if (ld_xfer_p0) begin
        we_lo_p0 = 1'b1;
        we_hi_p0 = 1'b1;
        widx_p0  = ld_ptr;
        wdata_p0 = ld_data;
      end else if (do_wr_p0) begin
        widx_p0 = idx_p0;
        if (word_mode) begin
          we_lo_p0 = 1'b1;
          we_hi_p0 = 1'b1;
          wdata_p0 = in;
        end else begin
          we_lo_p0 = !addr[0];
          we_hi_p0 = addr[0];
          wdata_p0 = {in[7:0], in[7:0]};
        end
      end
    end
  end

  // Stage p1: array update (data, never reset)
  always_ff @(negedge clk) begin
    if (we_lo_p0) mem[widx_p0][7:0]  <= wdata_p0[7:0];
    if (we_hi_p0) mem[widx_p0][15:8] <= wdata_p0[15:8];
  end

  // Stage p1: sequencing and registered read/error outputs
  always_ff @(negedge clk) begin
    if (!proc_rst) begin
      state       <= ST_INIT;
      clr_ptr     <= '0;
      ld_ptr      <= '0;
      ld_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      out_p1      <= '0;
      vld_p1      <= 1'b0;
      err_p1      <= 1'b0;
    end else begin
      vld_p1 <= do_rd_p0;
      err_p1 <= misalign_p0;
      if (do_rd_p0) out_p1 <= rd_val_p0;
      case (state)
        ST_INIT: begin
          if (!CLEAR_ON_RST || clr_ptr == LAST_IDX) begin
            if (LOAD_EN) begin
              state      <= ST_LOAD;
              ld_ready_q <= 1'b1;
            end else begin
              state       <= ST_RUN;
              mem_ready_q <= 1'b1;
            end
          end else begin
            clr_ptr <= clr_ptr + IDX_W'(1);
          end
        end
        ST_LOAD: begin
          if (ld_xfer_p0) begin
            // The last slot ends the load itself so ld_ptr never wraps
            if (ld_last || ld_ptr == LAST_IDX) begin
              state       <= ST_RUN;
              ld_ready_q  <= 1'b0;
              mem_ready_q <= 1'b1;
            end else begin
              ld_ptr <= ld_ptr + IDX_W'(1);
            end
          end
        end
        ST_RUN: state <= ST_RUN;
        default: begin
          state       <= ST_INIT;
          ld_ready_q  <= 1'b0;
          mem_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ld_ready  = ld_ready_q;
  assign mem_ready = mem_ready_q;
  assign out       = out_p1;
  assign out_valid = vld_p1;
  assign err_align = err_p1;

endmodule

// File: doc/boot_loaded_memory.md
Name: boot_loaded_memory

Overview:
- Parametrised successor to the processor's unified 16-bit instruction/data memory.
- Adds three capabilities:
  - a hardware clear sequence after reset;
  - a streaming boot-loader phase that fills program memory before the core runs, replacing hard-coded program images;
  - byte/word access mode with alignment checking.
- Sits between the multicycle datapath (addr/in/out, active-low strobes) and an external program source (UART/JTAG loader).

Parameters:
- ADDR_W, 7: byte-address width. DEPTH = 2**(ADDR_W-1) words of 16 bits.
- CLEAR_ON_RST, 1: 1 = INIT writes zero to every word; 0 = INIT lasts one cycle.
- LOAD_EN, 1: 1 = LOAD phase follows INIT; 0 = INIT goes straight to RUN.

Ports:
- clk  in  1  clock; all state updates on falling edge.
- proc_rst  in  1  synchronous active-low reset, sampled on falling edge of clk.
- ld_valid  in  1  loader word valid.
- ld_data  in  16  loader word.
- ld_last  in  1  marks final loader word.
- ld_ready  out  1  loader may transfer (LOAD state only).
- mem_ready  out  1  high in RUN; datapath may access.
- addr  in  ADDR_W  byte address.
- in  in  16  write data.
- word_mode  in  1  1 = 16-bit access, 0 = 8-bit access.
- write  in  1  active-low write strobe.
- read  in  1  active-low read strobe.
- out  out  16  registered read data.
- out_valid  out  1  one-cycle pulse when out updated.
- err_align  out  1  one-cycle pulse on misaligned word access.

Behaviour:
- Reset (proc_rst=0 at an edge):
  - state=INIT, clr_ptr=0, ld_ptr=0.
  - out=0, out_valid=0, err_align=0, ld_ready=0, mem_ready=0.
  - Array contents are not reset directly.
  - Reset asserted mid-INIT, mid-LOAD or mid-RUN aborts immediately; loader progress is discarded.
- States:
  - INIT:
    - CLEAR_ON_RST=1: writes 0 to mem[clr_ptr] and increments clr_ptr each cycle. After clr_ptr==DEPTH-1 is written, goes to LOAD (LOAD_EN=1) or RUN. Lasts exactly DEPTH cycles.
    - CLEAR_ON_RST=0: one cycle, then next state.
  - LOAD:
    - ld_ready=1.
    - Transfer occurs when ld_valid=1 and ld_ready=1 at an edge: mem[ld_ptr]<=ld_data, ld_ptr++.
    - After a transfer with ld_last=1, or with ld_ptr==DEPTH-1, ld_ready drops and the next state is RUN.
    - ld_ptr never wraps; excess words are refused via ld_ready=0.
    - ld_valid low stalls indefinitely.
  - RUN:
    - mem_ready=1, ld_ready=0.
    - Terminal until reset.
- read/write outside RUN are ignored: no array write, no out_valid, no err_align.
- Word index = addr[ADDR_W-1:1]. Byte select = addr[0] (0 = bits 7:0, 1 = bits 15:8).
- Word write (word_mode=1, write=0, addr[0]=0): mem[idx]<=in.
- Byte write (word_mode=0, write=0): only the selected byte is replaced, with in[7:0]; the other byte is preserved.
- Word read (read=0, word_mode=1, addr[0]=0): out<=mem[idx]; out_valid=1 next cycle. Latency 1.
- Byte read: out<=sign-extended selected byte.
- Misaligned word access (word_mode=1, addr[0]=1, read=0 or write=0):
  - Access is suppressed; out is unchanged.
  - err_align=1 for one cycle; out_valid=0.
- read and write both low, same address: out returns the pre-write contents (read-before-write). The write still commits.
- out holds its value when no read occurs.
- out_valid and err_align are single-cycle pulses; back-to-back reads give continuous out_valid.

Test Plan:
- Clear: ADDR_W=7, CLEAR_ON_RST=1, LOAD_EN=0, reset released -> mem_ready rises after exactly 64 cycles; word reads of addr 0, 62, 126 return 0x0000.
- Boot load: stream 0x801D, 0x4985, 0x4D85 with ld_last on the 3rd; insert one ld_valid=0 bubble -> ld_ready drops after the 3rd transfer; RUN entered; word reads of addr 0/2/4 return those values, each with a 1-cycle out_valid; addr 6 reads 0x0000.
- Byte ops: word write 0x1234 to addr 8; byte write 0xAB to addr 9 -> word read 0xAB34; byte read addr 9 -> 0xFFAB; byte read addr 8 -> 0x0034.
- Alignment: word read of addr 5 with out=0xAB34 -> err_align pulses 1 cycle, out stays 0xAB34, out_valid=0; word write of addr 5 leaves mem unchanged.
- Collision and gating: mem[10]=0x0001; read=0 and write=0 with in=0x00FF at addr 20 -> out=0x0001, subsequent read 0x00FF; strobes during LOAD have no effect.
- Reset mid-load: assert proc_rst after 2 of 5 loader words -> state INIT, ld_ptr=0; memory cleared again; reload of 5 words is accepted from address 0.
